regfile_write_arbiter: RTL

Shares the register file's single synchronous write port between two writeback requesters: port A (ALU result) and port B (load/memory result). Each port has a one-entry buffer with a valid/ready handshake. The arbiter grants one buffered write per cycle, and the grant drives WriteRegister/WriteData/RegWrite of the regfile directly. It also reports per-read-port hazards against writes that are buffered but not yet committed.

---
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter sharing the register file's single write port.
// Each requester has a one-entry buffer; pending entries are snooped for read hazards.
module regfile_write_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        AValid,
    input  logic [4:0]  AAddr,
    input  logic [31:0] AData,
    output logic        AReady,
    input  logic        BValid,
    input  logic [4:0]  BAddr,
    input  logic [31:0] BData,
    output logic        BReady,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic        Hazard1,
    output logic        Hazard2,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    logic        a_full_q, a_full_d;
    logic [4:0]  a_addr_q, a_addr_d;
    logic [31:0] a_data_q, a_data_d;
    logic        b_full_q, b_full_d;
    logic [4:0]  b_addr_q, b_addr_d;
    logic [31:0] b_data_q, b_data_d;
    port_e       last_q, last_d;
    port_e       older_q, older_d;

    logic grant_a, grant_b;
    logic a_push, b_push;
    logic a_keep, b_keep;

    // Equal addresses always follow fill order so per-register write order holds.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_full_q && b_full_q) begin
            if (a_addr_q == b_addr_q) begin
                if (older_q == PORT_A) grant_a = 1'b1;
                else                   grant_b = 1'b1;
            end else if (ROUND_ROBIN && (last_q == PORT_A)) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end else if (a_full_q) begin
            grant_a = 1'b1;
        end else if (b_full_q) begin
            grant_b = 1'b1;
        end
    end

    always_comb begin
        AReady = Reset_n & (~a_full_q | grant_a);
        BReady = Reset_n & (~b_full_q | grant_b);
        a_push = AValid & AReady;
        b_push = BValid & BReady;
        a_keep = a_full_q & ~grant_a;
        b_keep = b_full_q & ~grant_b;

        a_full_d = a_push | a_keep;
        a_addr_d = a_push ? AAddr : a_addr_q;
        a_data_d = a_push ? AData : a_data_q;
        b_full_d = b_push | b_keep;
        b_addr_d = b_push ? BAddr : b_addr_q;
        b_data_d = b_push ? BData : b_data_q;

        last_d = last_q;
        if (grant_a)      last_d = PORT_A;
        else if (grant_b) last_d = PORT_B;

        // A refill counts as a new entry, so the untouched buffer becomes older.
        older_d = older_q;
        if (a_push && b_push) older_d = PORT_A;
        else if (a_push)      older_d = b_keep ? PORT_B : PORT_A;
        else if (b_push)      older_d = a_keep ? PORT_A : PORT_B;
    end

    always_comb begin
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        if (grant_a) begin
            RegWrite      = |a_addr_q;
            WriteRegister = a_addr_q;
            WriteData     = a_data_q;
        end else if (grant_b) begin
            RegWrite      = |b_addr_q;
            WriteRegister = b_addr_q;
            WriteData     = b_data_q;
        end

        Hazard1 = (a_full_q && (a_addr_q == ReadRegister1) && (a_addr_q != 5'd0)) ||
                  (b_full_q && (b_addr_q == ReadRegister1) && (b_addr_q != 5'd0));
        Hazard2 = (a_full_q && (a_addr_q == ReadRegister2) && (a_addr_q != 5'd0)) ||
                  (b_full_q && (b_addr_q == ReadRegister2) && (b_addr_q != 5'd0));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_full_q <= 1'b0;
            a_addr_q <= '0;
            a_data_q <= '0;
            b_full_q <= 1'b0;
            b_addr_q <= '0;
            b_data_q <= '0;
            last_q   <= PORT_B;
            older_q  <= PORT_A;
        end else begin
            a_full_q <= a_full_d;
            a_addr_q <= a_addr_d;
            a_data_q <= a_data_d;
            b_full_q <= b_full_d;
            b_addr_q <= b_addr_d;
            b_data_q <= b_data_d;
            last_q   <= last_d;
            older_q  <= older_d;
        end
    end

endmodule
